// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU: grants a request,
// drives the ALU for a fixed latency, then returns the captured result.
module alu_arbiter #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int ALU_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*WIDTH-1:0]     req_opa,
  input  logic [2*WIDTH-1:0]     req_opb,
  input  logic [2*CMD_WIDTH-1:0] req_cmd,
  input  logic [1:0]             req_mode,
  input  logic [1:0]             req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [2*WIDTH-1:0]     rsp_res,
  output logic                   rsp_cout,
  output logic                   rsp_oflow,
  output logic                   rsp_err,
  output logic [2:0]             rsp_egl,
  output logic                   alu_ce,
  output logic [1:0]             alu_inp_valid,
  output logic [WIDTH-1:0]       alu_opa,
  output logic [WIDTH-1:0]       alu_opb,
  output logic [CMD_WIDTH-1:0]   alu_cmd,
  output logic                   alu_mode,
  output logic                   alu_cin,
  input  logic [2*WIDTH-1:0]     alu_res,
  input  logic                   alu_cout,
  input  logic                   alu_oflow,
  input  logic                   alu_e,
  input  logic                   alu_g,
  input  logic                   alu_l,
  input  logic                   alu_err,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response retires on the edge where rsp_valid & rsp_ready.

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 last_grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     opa_q, opb_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 mode_q, cin_q;
  logic                 ce_q;
  logic [1:0]           inp_valid_q;
  logic                 rsp_valid_q, rsp_id_q;
  logic [2*WIDTH-1:0]   rsp_res_q;
  logic                 rsp_cout_q, rsp_oflow_q, rsp_err_q;
  logic [2:0]           rsp_egl_q;

  logic [1:0]           grant;
  logic                 gidx;
  logic                 xfer;
  logic [WIDTH-1:0]     opa_d, opb_d;
  logic [CMD_WIDTH-1:0] cmd_d;
  logic                 mode_d, cin_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    if (rst && (state_q == S_IDLE)) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gidx   = grant[1];
  assign xfer   = |(req_valid & grant);
  assign opa_d  = gidx ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
  assign opb_d  = gidx ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
  assign cmd_d  = gidx ? req_cmd[2*CMD_WIDTH-1:CMD_WIDTH] : req_cmd[CMD_WIDTH-1:0];
  assign mode_d = req_mode[gidx];
  assign cin_d  = req_cin[gidx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      cmd_q        <= '0;
      mode_q       <= 1'b0;
      cin_q        <= 1'b0;
      ce_q         <= 1'b0;
      inp_valid_q  <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_oflow_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_egl_q    <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            cmd_q        <= cmd_d;
            mode_q       <= mode_d;
            cin_q        <= cin_d;
            rsp_id_q     <= gidx;
            last_grant_q <= gidx;
            ce_q         <= 1'b1;
            inp_valid_q  <= 2'b11;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CNT_W'(ALU_LAT);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rsp_res_q   <= alu_res;
            rsp_cout_q  <= alu_cout;
            rsp_oflow_q <= alu_oflow;
            rsp_err_q   <= alu_err;
            rsp_egl_q   <= {alu_e, alu_g, alu_l};
            rsp_valid_q <= 1'b1;
            ce_q        <= 1'b0;
            inp_valid_q <= 2'b00;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = grant;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_res       = rsp_res_q;
  assign rsp_cout      = rsp_cout_q;
  assign rsp_oflow     = rsp_oflow_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_egl       = rsp_egl_q;
  assign alu_ce        = ce_q;
  assign alu_inp_valid = inp_valid_q;
  assign alu_opa       = opa_q;
  assign alu_opb       = opb_q;
  assign alu_cmd       = cmd_q;
  assign alu_mode      = mode_q;
  assign alu_cin       = cin_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared `alu` datapath. It accepts operation requests (operands, command, mode, carry-in) from two clients, grants one at a time, and drives the ALU with `ce`/`inp_valid`. It waits a fixed ALU latency, captures the result and flags, and returns them on a single response channel tagged with the requester id. It sits between client logic and one `alu` instance; exactly one operation is in flight at any time.

## Interface
- `WIDTH`, 8, operand width; the result is 2*WIDTH.
- `CMD_WIDTH`, 4, ALU command width.
- `ALU_LAT`, 2, cycles from ALU issue to valid ALU outputs; legal values are ≥1.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i is requester i.
- `req_ready`  out  2  per-requester accept; at most one bit is high.
- `req_opa`, `req_opb`  in  2*WIDTH each  packed as {req1, req0}.
- `req_cmd`  in  2*CMD_WIDTH  packed as {req1, req0}.
- `req_mode`, `req_cin`  in  2 each  per-requester mode and carry-in.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  index of the requester served.
- `rsp_res`  out  2*WIDTH  captured ALU result.
- `rsp_cout`, `rsp_oflow`, `rsp_err`  out  1 each  captured ALU flags.
- `rsp_egl`  out  3  captured {e, g, l}.
- `alu_ce`  out  1  ALU clock enable.
- `alu_inp_valid`  out  2  ALU input-valid; the block drives 2'b11 when active, 2'b00 otherwise.
- `alu_opa`, `alu_opb`  out  WIDTH each  ALU operands.
- `alu_cmd`  out  CMD_WIDTH  ALU command.
- `alu_mode`, `alu_cin`  out  1 each  ALU mode and carry-in.
- `alu_res`  in  2*WIDTH  ALU result.
- `alu_cout`, `alu_oflow`, `alu_e`, `alu_g`, `alu_l`, `alu_err`  in  1 each  ALU flags.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE: grant selection.** `req_ready` is combinational and equals the one-hot grant.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester other than `last_grant` is granted.
  - If neither is valid, no grant is made.
- **IDLE: handshake.** A transfer occurs when `req_valid[g] & req_ready[g]`. On a transfer:
  - the request fields are latched into holding registers;
  - `rsp_id` is set to g;
  - `last_grant` is set to g;
  - the FSM goes to ISSUE.
- **IDLE: withdrawn request.** If a requester drops valid before it is granted, no transfer occurs and `last_grant` is unchanged.
- **ISSUE (1 cycle).** `alu_ce=1` and `alu_inp_valid=2'b11`. The latency counter loads `ALU_LAT`. Next state is WAIT.
- **WAIT (exactly `ALU_LAT` cycles).** `alu_ce` and `alu_inp_valid` stay asserted, and the counter decrements. On the edge where the counter is 1:
  - `alu_res`, the flags and `{alu_e, alu_g, alu_l}` are captured into the `rsp_*` registers;
  - the FSM goes to RESP.
- **RESP.** `rsp_valid=1`, `alu_ce=0`, `alu_inp_valid=2'b00`. The FSM stays in RESP until `rsp_valid & rsp_ready`, then returns to IDLE.
- **ALU operand outputs.** `alu_opa`, `alu_opb`, `alu_cmd`, `alu_mode` and `alu_cin` always reflect the holding registers. They are stable from ISSUE through RESP.
- **`req_ready` outside IDLE.** It is 2'b00 in every state other than IDLE and while `rst` is low.

## Timing
- **Reset (`rst`=0, asynchronous).**
  - State becomes IDLE and `last_grant` becomes 1, so requester 0 wins the first tie.
  - All outputs and holding registers are cleared to 0.
  - `alu_inp_valid` is 2'b00.
- **Latency.** Take the acceptance edge as the end of cycle 0.
  - Cycle 1 is ISSUE.
  - Cycles 2 to `ALU_LAT`+1 are WAIT.
  - `rsp_valid` rises in cycle `ALU_LAT`+2.
- **Throughput.** With `rsp_ready` held at 1, a new grant occurs at most every `ALU_LAT`+3 cycles.
- **Back-pressure.** While `rsp_valid & !rsp_ready`, every `rsp_*` output holds stable and no request is accepted.
- **Reset mid-operation.** The in-flight operation is discarded:
  - no response is produced for it;
  - `alu_ce` and `alu_inp_valid` drop immediately;
  - after release, the first tie is granted to requester 0.
- **Simultaneous `rsp_ready` and a new `req_valid` in RESP.** The FSM returns to IDLE; the grant happens in the following cycle.

## Test plan
Parameters for all scenarios: `WIDTH`=8, `ALU_LAT`=2, and ADD is `mode`=1, `cmd`=0. A reference ALU model supplies `alu_*` outputs after 2 cycles.

- **Reset:** hold `rst` low with `req_valid`=2'b11 → `req_ready`=00, `rsp_valid`=0, `alu_inp_valid`=00, `busy`=0.
- **Single request:** req0 ADD with opa=200, opb=100 and `rsp_ready`=1.
  - `req_ready`=01 in cycle 0.
  - `alu_inp_valid`=11 in cycles 1–3.
  - `rsp_valid` in cycle 4 with `rsp_res`=16'd300, `rsp_id`=0.
- **Tie round-robin:** both requesters valid continuously with `rsp_ready`=1 → four responses with `rsp_id` sequence 0, 1, 0, 1, each 5 cycles apart.
- **Back-pressure:** hold `rsp_ready`=0 for 10 cycles after `rsp_valid` rises, with req1 pending.
  - `rsp_*` stays stable and `req_ready`=00 throughout.
  - After `rsp_ready` pulses, req1 is granted in the next cycle.
- **Reset mid-WAIT:** assert `rst` low in cycle 2 of a req1 operation.
  - All outputs clear asynchronously.
  - After release, with both requesters valid, requester 0 is granted and no stale response appears.
- **Withdrawn request:** req1 valid for 1 cycle while the FSM is busy, then dropped; req0 issues later → req1 is never granted and `last_grant` changes only on req0's handshake.
